// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Memory/writeback boundary stage: ALU pass-through, load/store
//               via req/ack handshake, architectural eq/gt flags register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int RD_W    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic              in_is_ld,
    input  logic              in_is_st,
    input  logic              in_is_cmp,
    input  logic              in_flags_eq,
    input  logic              in_flags_gt,
    input  logic              in_wb_en,
    input  logic [RD_W-1:0]   in_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wb_en,
    output logic              out_err,
    output logic              flags_eq,
    output logic              flags_gt
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_OUT_HOLD = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend_ld;
    logic             r_pend_wb_en;
    logic [RD_W-1:0]  r_pend_rd;

    logic w_accept;
    logic w_is_mem;
    logic w_err;

    // Gated by rst_n so every output reads 0 while reset is held.
    assign in_ready = rst_n && (r_state == S_IDLE) && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_is_mem = in_is_ld || in_is_st;
    // Alignment only matters when the ALU result is used as an address.
    assign w_err    = (in_is_ld && in_is_st) || (w_is_mem && (in_alu_result[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pend_ld    <= 1'b0;
            r_pend_wb_en <= 1'b0;
            r_pend_rd    <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_rd       <= '0;
            out_wb_en    <= 1'b0;
            out_err      <= 1'b0;
            flags_eq     <= 1'b0;
            flags_gt     <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (in_is_cmp) begin
                            flags_eq <= in_flags_eq;
                            flags_gt <= in_flags_gt;
                        end
                        if (w_err) begin
                            out_valid  <= 1'b1;
                            out_result <= in_alu_result;
                            out_rd     <= in_rd;
                            out_wb_en  <= 1'b0;
                            out_err    <= 1'b1;
                            r_state    <= out_ready ? S_IDLE : S_OUT_HOLD;
                        end else if (w_is_mem) begin
                            mem_req      <= 1'b1;
                            mem_we       <= in_is_st;
                            mem_addr     <= in_alu_result;
                            mem_wdata    <= in_store_data;
                            r_cnt        <= '0;
                            r_pend_ld    <= in_is_ld;
                            r_pend_wb_en <= in_wb_en;
                            r_pend_rd    <= in_rd;
                            r_state      <= S_MEM_WAIT;
                        end else begin
                            out_valid  <= 1'b1;
                            out_result <= in_alu_result;
                            out_rd     <= in_rd;
                            out_wb_en  <= in_wb_en;
                            out_err    <= 1'b0;
                            r_state    <= out_ready ? S_IDLE : S_OUT_HOLD;
                        end
                    end
                end

                S_MEM_WAIT: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        out_valid  <= 1'b1;
                        out_result <= r_pend_ld ? mem_rdata : mem_addr;
                        out_rd     <= r_pend_rd;
                        out_wb_en  <= r_pend_ld && r_pend_wb_en;
                        out_err    <= 1'b0;
                        r_state    <= S_OUT_HOLD;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        // Abort on the edge where unacknowledged wait cycles reach TIMEOUT.
                        mem_req    <= 1'b0;
                        out_valid  <= 1'b1;
                        out_result <= mem_addr;
                        out_rd     <= r_pend_rd;
                        out_wb_en  <= 1'b0;
                        out_err    <= 1'b1;
                        r_state    <= S_OUT_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_OUT_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench with an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int DATA_W  = 32;
    localparam int RD_W    = 4;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_store_data;
    logic              in_is_ld;
    logic              in_is_st;
    logic              in_is_cmp;
    logic              in_flags_eq;
    logic              in_flags_gt;
    logic              in_wb_en;
    logic [RD_W-1:0]   in_rd;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_wb_en;
    logic              out_err;
    logic              flags_eq;
    logic              flags_gt;

    typedef struct {
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic              wb_en;
        logic              err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_alu_result(in_alu_result),
        .in_store_data(in_store_data),
        .in_is_ld     (in_is_ld),
        .in_is_st     (in_is_st),
        .in_is_cmp    (in_is_cmp),
        .in_flags_eq  (in_flags_eq),
        .in_flags_gt  (in_flags_gt),
        .in_wb_en     (in_wb_en),
        .in_rd        (in_rd),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_wb_en    (out_wb_en),
        .out_err      (out_err),
        .flags_eq     (flags_eq),
        .flags_gt     (flags_gt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic cmp,
                         input logic eq, input logic gt, input logic [DATA_W-1:0] alu,
                         input logic [DATA_W-1:0] sdata, input logic wb, input logic [RD_W-1:0] rd);
        in_valid      = v;
        in_is_ld      = ld;
        in_is_st      = st;
        in_is_cmp     = cmp;
        in_flags_eq   = eq;
        in_flags_gt   = gt;
        in_alu_result = alu;
        in_store_data = sdata;
        in_wb_en      = wb;
        in_rd         = rd;
    endtask

    task automatic push(input logic [DATA_W-1:0] res, input logic [RD_W-1:0] rd,
                        input logic wb, input logic err);
        exp_t e;
        e.result = res;
        e.rd     = rd;
        e.wb_en  = wb;
        e.err    = err;
        sb.push_back(e);
    endtask

    // Waits (bounded) for a retired result and compares it with the queue head.
    task automatic expect_out(input string tag);
        exp_t e;
        int   n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, ".valid"}, DATA_W'(out_valid), DATA_W'(1));
        chk({tag, ".queued"}, DATA_W'(sb.size() > 0), DATA_W'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".result"}, out_result, e.result);
            chk({tag, ".rd"}, DATA_W'(out_rd), DATA_W'(e.rd));
            chk({tag, ".wb_en"}, DATA_W'(out_wb_en), DATA_W'(e.wb_en));
            chk({tag, ".err"}, DATA_W'(out_err), DATA_W'(e.err));
        end
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        drive(0, 0, 0, 0, 0, 0, '0, '0, 0, '0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst.out_valid", DATA_W'(out_valid), '0);
        chk("rst.mem_req", DATA_W'(mem_req), '0);
        chk("rst.flags", DATA_W'({flags_eq, flags_gt}), '0);
        chk("rst.in_ready", DATA_W'(in_ready), DATA_W'(1));

        // Back-to-back ALU results at one per cycle
        drive(1, 0, 0, 0, 0, 0, 32'h5, '0, 1, 4'd3);
        push(32'h5, 4'd3, 1, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 32'h9, '0, 1, 4'd4);
        push(32'h9, 4'd4, 1, 0);
        chk("b2b.in_ready0", DATA_W'(in_ready), DATA_W'(1));
        expect_out("b2b0");
        tick();
        chk("b2b.in_ready1", DATA_W'(in_ready), DATA_W'(1));
        expect_out("b2b1");
        drive(0, 0, 0, 0, 0, 0, '0, '0, 0, '0);
        tick();
        chk("b2b.drain", DATA_W'(out_valid), '0);

        // Compare sets the flags
        drive(1, 0, 0, 1, 1, 0, 32'h0, '0, 0, 4'd0);
        push(32'h0, 4'd0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, '0, '0, 0, '0);
        chk("cmp.flags", DATA_W'({flags_eq, flags_gt}), DATA_W'(2'b10));
        expect_out("cmp");
        tick();

        // Load, ack on third wait cycle
        drive(1, 1, 0, 0, 0, 0, 32'h100, '0, 1, 4'd5);
        push(32'hDEADBEEF, 4'd5, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, '0, '0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            chk("ld.mem_req", DATA_W'(mem_req), DATA_W'(1));
            chk("ld.mem_addr", mem_addr, 32'h100);
            chk("ld.mem_we", DATA_W'(mem_we), '0);
            if (i == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEADBEEF;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("ld.req_drop", DATA_W'(mem_req), '0);
        expect_out("ld");
        chk("ld.flags", DATA_W'({flags_eq, flags_gt}), DATA_W'(2'b10));
        tick();

        // Store, ack in first wait cycle
        drive(1, 0, 1, 0, 0, 0, 32'h104, 32'h1234, 1, 4'd6);
        push(32'h104, 4'd6, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, '0, '0, 0, '0);
        chk("st.mem_req", DATA_W'(mem_req), DATA_W'(1));
        chk("st.mem_we", DATA_W'(mem_we), DATA_W'(1));
        chk("st.mem_wdata", mem_wdata, 32'h1234);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("st.req_drop", DATA_W'(mem_req), '0);
        expect_out("st");
        tick();

        // Misaligned load, then ld&st both set
        drive(1, 1, 0, 0, 0, 0, 32'h102, '0, 1, 4'd7);
        push(32'h102, 4'd7, 0, 1);
        tick();
        drive(1, 1, 1, 0, 0, 0, 32'h200, '0, 1, 4'd8);
        push(32'h200, 4'd8, 0, 1);
        chk("mis.mem_req", DATA_W'(mem_req), '0);
        expect_out("mis");
        tick();
        drive(0, 0, 0, 0, 0, 0, '0, '0, 0, '0);
        chk("ldst.mem_req", DATA_W'(mem_req), '0);
        expect_out("ldst");
        tick();

        // Timeout: ack never arrives in time
        drive(1, 1, 0, 0, 0, 0, 32'h300, '0, 1, 4'd9);
        push(32'h300, 4'd9, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, '0, '0, 0, '0);
        n = 0;
        while (mem_req === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("to.wait_cycles", DATA_W'(n), DATA_W'(TIMEOUT));
        expect_out("to");
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("to.late_ack_valid", DATA_W'(out_valid), '0);
        chk("to.late_ack_req", DATA_W'(mem_req), '0);

        // Load held in output register while writeback stalls
        out_ready = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 32'h400, '0, 1, 4'd10);
        push(32'hCAFEF00D, 4'd10, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, '0, '0, 0, '0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        mem_rdata = '0;
        drive(1, 0, 0, 0, 0, 0, 32'h77, '0, 1, 4'd11);
        for (int i = 0; i < 5; i++) begin
            chk("hold.valid", DATA_W'(out_valid), DATA_W'(1));
            chk("hold.result", out_result, 32'hCAFEF00D);
            chk("hold.in_ready", DATA_W'(in_ready), '0);
            chk("hold.flags", DATA_W'({flags_eq, flags_gt}), DATA_W'(2'b10));
            tick();
        end
        out_ready = 1'b1;
        expect_out("hold");
        tick();
        push(32'h77, 4'd11, 1, 0);
        chk("hold.in_ready_rise", DATA_W'(in_ready), DATA_W'(1));
        tick();
        drive(0, 0, 0, 0, 0, 0, '0, '0, 0, '0);
        expect_out("after_hold");
        tick();

        // Asynchronous reset in the middle of a memory wait
        drive(1, 1, 0, 0, 0, 0, 32'h500, '0, 1, 4'd12);
        tick();
        drive(0, 0, 0, 0, 0, 0, '0, '0, 0, '0);
        chk("arst.pre_req", DATA_W'(mem_req), DATA_W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.mem_req", DATA_W'(mem_req), '0);
        chk("arst.out_valid", DATA_W'(out_valid), '0);
        chk("arst.flags", DATA_W'({flags_eq, flags_gt}), '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst.in_ready", DATA_W'(in_ready), DATA_W'(1));
        chk("arst.mem_req_after", DATA_W'(mem_req), '0);
        chk("sb.empty", DATA_W'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory/writeback-boundary stage directly downstream of the ALU.
- Consumes the ALU result, the ALU compare flags and the decoded control bits for one instruction at a time.
- Performs a load or store through a req/ack data-memory handshake, or passes the ALU result straight through.
- Holds the architectural eq/gt flags register and presents one retired result per instruction to the register-file writeback.

Parameters:
- DATA_W, 32, width of ALU result, store data and memory data
- RD_W, 4, width of destination register index
- TIMEOUT, 255, max cycles waiting for mem_ack before the access aborts with error

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction
- in_alu_result  in  DATA_W  ALU result; used as address for ld/st
- in_store_data  in  DATA_W  store data (rd register value)
- in_is_ld  in  1  load instruction
- in_is_st  in  1  store instruction
- in_is_cmp  in  1  compare instruction; update flags
- in_flags_eq  in  1  ALU eq flag
- in_flags_gt  in  1  ALU gt flag
- in_wb_en  in  1  instruction writes rd
- in_rd  in  RD_W  destination register
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  DATA_W  byte address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  memory completion, sampled only while mem_req = 1
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- out_valid  out  1  retired result valid
- out_ready  in  1  writeback accepts
- out_result  out  DATA_W  load data or ALU result
- out_rd  out  RD_W  destination register
- out_wb_en  out  1  write register file
- out_err  out  1  misaligned, illegal or timed-out access
- flags_eq  out  1  architectural eq flag
- flags_gt  out  1  architectural gt flag

Behaviour:
- Reset (async, immediate, including mid-access):
  - All outputs 0; mem_req drops asynchronously.
  - FSM goes to IDLE; timeout counter is cleared.
- FSM states: IDLE, MEM_WAIT, OUT_HOLD.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Flags:
  - On accept with in_is_cmp = 1, flags_eq/flags_gt load the in_flags values, visible the next cycle.
  - They are otherwise held, and are never touched by the memory path.
- Non-memory accept (ld = st = 0):
  - At the accepting edge: out_result = in_alu_result, out_rd/out_wb_en captured, out_err = 0, out_valid = 1.
  - Latency is 1 cycle. FSM goes to IDLE if out_ready was sampled, else OUT_HOLD.
- Error accept (ld & st both 1, or in_alu_result[1:0] != 0):
  - No memory request is issued.
  - out_valid = 1, out_err = 1, out_wb_en = 0, out_result = in_alu_result.
- Memory accept:
  - At the accepting edge, register mem_req = 1, mem_we = in_is_st, mem_addr = in_alu_result, mem_wdata = in_store_data.
  - FSM goes to MEM_WAIT and the timeout counter resets to 0.
- MEM_WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack.
  - The counter increments each cycle without ack.
  - On ack: mem_req = 0 next cycle and out_valid = 1. A load gives out_result = mem_rdata and out_wb_en = in_wb_en. A store gives out_result = address and out_wb_en = 0. out_err = 0. FSM goes to OUT_HOLD.
  - On counter == TIMEOUT with no ack: mem_req = 0, out_valid = 1, out_err = 1, out_wb_en = 0.
  - An ack arriving after abort is ignored.
- OUT_HOLD:
  - Outputs are held stable while out_valid && !out_ready.
  - On out_ready the next edge clears out_valid and the FSM goes to IDLE.
  - A new instruction is accepted no earlier than the cycle in_ready rises.
  - Back-to-back non-memory ops with out_ready held at 1 sustain 1 instruction per cycle, since in_ready stays 1 in IDLE.
- Only one instruction is in flight at a time; no buffering beyond the single output register.

Test Plan:
- Reset asserted mid MEM_WAIT (mem_req = 1) -> mem_req, out_valid and flags go to 0 immediately; after release in_ready = 1.
- Back-to-back ADD results 0x5 then 0x9, rd = 3/4, out_ready = 1 -> out_valid on 2 consecutive cycles with out_result 0x5 then 0x9; in_ready stays 1.
- Load addr 0x100, mem_ack after 3 cycles with rdata 0xDEADBEEF -> mem_req high 3 cycles with address stable; then out_result = 0xDEADBEEF, out_wb_en = 1.
- Store addr 0x104, data 0x1234, ack in first wait cycle -> mem_we = 1, mem_wdata = 0x1234; then out_valid = 1, out_wb_en = 0.
- Misaligned load addr 0x102, and separately ld&st both set -> no mem_req; out_err = 1, out_wb_en = 0. With TIMEOUT = 4 and ack never arriving -> out_err after 4 wait cycles.
- cmp with eq = 1, gt = 0, then load with out_ready = 0 for 5 cycles -> flags stay 1/0; outputs held stable; in_ready = 0 until out_ready = 1.
